imm_rot_encoder: RTL and testbench

- Inverse of the datapath rotate-immediate decode (operand2 = imm8 ROR 2*rot).
- Takes a 32-bit constant and searches iteratively, one rotation per cycle, for an (imm8, rot4) pair that reproduces it, choosing the lowest rot.
- Used by the constant-load / self-test sequencer to check whether a literal fits a data-processing immediate or needs a literal-pool load.
- Valid/ready handshake on both sides.

---
 rtl/imm_rot_encoder.sv | 140 ++++++++++++++
 tb/tb_imm_rot_encoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_rot_encoder.sv
// Rotate-immediate encoder: finds the lowest rot such that value == imm8 ROR (2*rot).
// Latency: r+1 cycles from accept to out_valid for a match at rot r; 16 for no match.
// Backpressure: the result is held in DONE until out_ready; in_ready is low until then.
module imm_rot_encoder #(
  parameter int DATAW = 32,
  parameter int IMMW  = 8,
  parameter int ROTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ok,
  output logic [IMMW-1:0]  out_imm,
  output logic [ROTW-1:0]  out_rot,
  output logic             out_cmod,
  output logic             out_carry
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ROTW-1:0] ROT_LAST = '1;

  state_t             state_q, state_d;
  logic [DATAW-1:0]   val_q, val_d;
  logic [ROTW-1:0]    rot_q, rot_d;
  logic               ok_q, ok_d;
  logic [IMMW-1:0]    imm_q, imm_d;
  logic [ROTW-1:0]    rot_res_q, rot_res_d;
  logic               cmod_q, cmod_d;
  logic               carry_q, carry_d;

  logic [ROTW:0]      shamt;
  logic [2*DATAW-1:0] dbl;
  logic [DATAW-1:0]   cand;
  logic               match;

  // Candidate for the current rot: value rotated left by 2*rot (undoes the decode ROR).
  always_comb begin
    shamt = {rot_q, 1'b0};
    dbl   = {val_q, val_q} << shamt;
    cand  = dbl[2*DATAW-1 -: DATAW];
    match = (cand[DATAW-1:IMMW] == '0);
  end

  // Next-state and result computation; rot counter is checked for terminal before incrementing.
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    rot_d     = rot_q;
    ok_d      = ok_q;
    imm_d     = imm_q;
    rot_res_d = rot_res_q;
    cmod_d    = cmod_q;
    carry_d   = carry_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d     = in_value;
          rot_d     = '0;
          ok_d      = 1'b0;
          imm_d     = '0;
          rot_res_d = '0;
          cmod_d    = 1'b0;
          carry_d   = 1'b0;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        if (match) begin
          ok_d      = 1'b1;
          imm_d     = cand[IMMW-1:0];
          rot_res_d = rot_q;
          cmod_d    = (rot_q != '0);
          carry_d   = (rot_q != '0) & val_q[DATAW-1];
          state_d   = DONE;
        end else if (rot_q == ROT_LAST) begin
          ok_d      = 1'b0;
          imm_d     = '0;
          rot_res_d = '0;
          cmod_d    = 1'b0;
          carry_d   = 1'b0;
          state_d   = DONE;
        end else begin
          rot_d = rot_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      val_q     <= '0;
      rot_q     <= '0;
      ok_q      <= 1'b0;
      imm_q     <= '0;
      rot_res_q <= '0;
      cmod_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      rot_q     <= rot_d;
      ok_q      <= ok_d;
      imm_q     <= imm_d;
      rot_res_q <= rot_res_d;
      cmod_q    <= cmod_d;
      carry_q   <= carry_d;
    end
  end

  // Handshake flags follow the state; result fields come straight from their registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_ok    = ok_q;
    out_imm   = imm_q;
    out_rot   = rot_res_q;
    out_cmod  = cmod_q;
    out_carry = carry_q;
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
module tb_imm_rot_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_ok;
  logic [7:0]  out_imm;
  logic [3:0]  out_rot;
  logic        out_cmod;
  logic        out_carry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_rot_encoder #(.DATAW(32), .IMMW(8), .ROTW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ok    (out_ok),
    .out_imm   (out_imm),
    .out_rot   (out_rot),
    .out_cmod  (out_cmod),
    .out_carry (out_carry)
  );

  typedef struct {
    logic [31:0] val;
    logic        ok;
    logic [7:0]  imm;
    logic [3:0]  rot;
    logic        cmod;
    logic        carry;
    int          lat;
    int          stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v >> s) | (v << (32 - s));
  endfunction

  // Issues one request and collects its result. pre_rdy drives out_ready during the
  // search (must have no effect); stall holds out_ready low in DONE while a competing
  // request (0x1) is presented and must not be accepted.
  task automatic run_req(input logic [31:0] v, input logic pre_rdy, input int stall,
                         output logic ok, output logic [7:0] imm, output logic [3:0] rot,
                         output logic cmod, output logic carry, output int lat,
                         output logic stable);
    logic [14:0] snap;
    @(negedge clk);
    in_valid  = 1'b1;
    in_value  = v;
    out_ready = pre_rdy;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_value = 32'hDEAD_BEEF;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout waiting for out_valid value=0x%08h", v);
    end
    ok = out_ok; imm = out_imm; rot = out_rot; cmod = out_cmod; carry = out_carry;
    snap = {out_ok, out_imm, out_rot, out_cmod, out_carry};
    stable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_value = 32'h1;
      @(negedge clk);
      if (!out_valid || in_ready ||
          snap != {out_ok, out_imm, out_rot, out_cmod, out_carry}) stable = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid || !in_ready) stable = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    logic ok, cmod, carry, stable;
    logic [7:0] imm;
    logic [3:0] rot;
    int lat;

    vecs[0] = '{32'h0000_0000, 1'b1, 8'h00, 4'd0,  1'b0, 1'b0, 1,  0};
    vecs[1] = '{32'h0000_00FF, 1'b1, 8'hFF, 4'd0,  1'b0, 1'b0, 1,  0};
    vecs[2] = '{32'hFF00_0000, 1'b1, 8'hFF, 4'd4,  1'b1, 1'b1, 5,  0};
    vecs[3] = '{32'hF000_000F, 1'b1, 8'hFF, 4'd2,  1'b1, 1'b1, 3,  0};
    vecs[4] = '{32'h0000_03FC, 1'b1, 8'hFF, 4'd15, 1'b1, 1'b0, 16, 0};
    vecs[5] = '{32'h0000_0101, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 16, 0};
    vecs[6] = '{32'h00AB_0000, 1'b1, 8'hAB, 4'd8,  1'b1, 1'b0, 9,  10};
    vecs[7] = '{32'h0000_0001, 1'b1, 8'h01, 4'd0,  1'b0, 1'b0, 1,  0};
    vecs[8] = '{32'h8000_0001, 1'b1, 8'h06, 4'd1,  1'b1, 1'b1, 2,  3};
    vecs[9] = '{32'h3FC0_0000, 1'b1, 8'hFF, 4'd5,  1'b1, 1'b0, 6,  0};

    reset = 1'b1; in_valid = 1'b0; in_value = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fields", {19'd0, out_ok, out_imm, out_rot, out_cmod, out_carry}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a search: immediate return to idle, no result.
    @(negedge clk);
    in_valid = 1'b1; in_value = 32'h0000_0101;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_result", {31'd0, seen}, 32'd0);
    end
    run_req(32'h0000_007F, 1'b1, 0, ok, imm, rot, cmod, carry, lat, stable);
    chk("post_rst_ok",  {31'd0, ok},  32'd1);
    chk("post_rst_imm", {24'd0, imm}, 32'h7F);
    chk("post_rst_rot", {28'd0, rot}, 32'd0);
    chk("post_rst_lat", lat, 1);

    foreach (vecs[k]) begin
      run_req(vecs[k].val, 1'b1, vecs[k].stall, ok, imm, rot, cmod, carry, lat, stable);
      chk($sformatf("v%0d_ok", k),     {31'd0, ok},    {31'd0, vecs[k].ok});
      chk($sformatf("v%0d_imm", k),    {24'd0, imm},   {24'd0, vecs[k].imm});
      chk($sformatf("v%0d_rot", k),    {28'd0, rot},   {28'd0, vecs[k].rot});
      chk($sformatf("v%0d_cmod", k),   {31'd0, cmod},  {31'd0, vecs[k].cmod});
      chk($sformatf("v%0d_carry", k),  {31'd0, carry}, {31'd0, vecs[k].carry});
      chk($sformatf("v%0d_lat", k),    lat,            vecs[k].lat);
      chk($sformatf("v%0d_stable", k), {31'd0, stable}, 32'd1);
    end

    // Random values: half built from a random (imm, rot), half fully random.
    begin
      int results = 0;
      int bad = 0;
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] v;
        logic        e_ok;
        int          e_rot;
        if ($urandom_range(1, 0) == 1)
          v = ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(15, 0)));
        else
          v = $urandom;
        e_ok = 1'b0; e_rot = 0;
        for (int r = 15; r >= 0; r--) begin
          if (rol32(v, 2 * r) < 32'd256) begin
            e_ok = 1'b1; e_rot = r;
          end
        end
        run_req(v, 1'($urandom), int'($urandom_range(2, 0)),
                ok, imm, rot, cmod, carry, lat, stable);
        if (lat < 40) results++;
        if (ok !== e_ok || !stable || lat != e_rot + (e_ok ? 1 : 16)) bad++;
        else if (e_ok && (ror32({24'd0, imm}, 2 * int'(rot)) !== v || int'(rot) != e_rot ||
                          cmod !== (rot != 0) || carry !== ((rot != 0) & v[31]))) bad++;
        else if (!e_ok && {imm, rot, cmod, carry} !== 14'd0) bad++;
        if (bad == 1 && n >= 0) begin
          $display("FAIL random value=0x%08h ok=%0b imm=0x%02h rot=%0d lat=%0d expected ok=%0b rot=%0d",
                   v, ok, imm, rot, lat, e_ok, e_rot);
          bad = 2;
        end
      end
      chk("random_results", results, 1000);
      chk("random_bad", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
